serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op_sub, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-007 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port result, output, WIDTH bits: sum or difference.
REQ-010 The block SHALL have port cout, output, 1 bit: final carry (not-borrow for subtract).
REQ-011 The block SHALL have port ovf, output, 1 bit: signed overflow.

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, through one shared 1-bit full-adder cell, with exactly one bit per clock cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on a clock edge with start=1, latching a, b, op_sub, clearing the bit counter, and loading carry-in = op_sub.
REQ-015 In RUN the block SHALL feed bit[k] of a and bit[k] of b XOR op_sub to the cell, store sum into result[k] and the carry into the carry register, then increment k.
REQ-016 RUN -> DONE SHALL occur after the edge processing bit WIDTH-1, i.e. after exactly WIDTH RUN cycles.
REQ-017 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-018 done SHALL be 1 only in DONE, so done asserts on the (WIDTH+1)th edge after the start edge.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored when not in IDLE; operand changes during RUN SHALL have no effect.
REQ-021 result and cout SHALL hold their values from DONE until the next accepted start.
REQ-022 On an accepted start, cout and ovf SHALL clear.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH: cout = carry out of bit WIDTH-1, ovf = carry into MSB XOR carry out of MSB.
REQ-024 Back-to-back operation: start held high SHALL be accepted again on the first IDLE cycle after DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE and clear the counter, carry, result, cout, ovf, busy and done to 0, including when reset is asserted mid-RUN, in which case the operation is discarded and no done is produced.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-027 When macro SERIAL_ADD_OVF_EN is defined, the block SHALL compute and hold ovf per REQ-023.
REQ-028 When SERIAL_ADD_OVF_EN is not defined, ovf SHALL be tied to constant 0 and the MSB-carry tracking logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state typedef (IDLE, RUN, DONE), the default WIDTH constant and the counter-width function (clog2 of WIDTH).
REQ-030 The 1-bit full-adder cell SHALL be a separate gate-level sub-module named fa_bit_cell (ports s, cout, a, b, cin), instantiated once.
REQ-031 The counter, carry register and FSM SHALL reside in serial_add_ctrl.

Verification (WIDTH=8)
REQ-032 The bench SHALL check: start, a=0x0F, b=0x01, add -> done on 9th edge, result=0x10, cout=0, ovf=0.
REQ-033 The bench SHALL check: a=0xFF, b=0x01, add -> result=0x00, cout=1, ovf=0.
REQ-034 The bench SHALL check: a=0x05, b=0x07, sub -> result=0xFE, cout=0; a=0x07, b=0x05, sub -> result=0x02, cout=1.
REQ-035 The bench SHALL check: a=0x7F, b=0x01, add -> result=0x80, ovf=1 with SERIAL_ADD_OVF_EN defined, ovf=0 without it.
REQ-036 The bench SHALL check: start pulsed again during RUN with different operands -> first result unaffected, exactly one done pulse.
REQ-037 The bench SHALL check: rst_n pulled low at RUN cycle 4 -> all outputs 0 immediately, no done, next start completes normally.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;

   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Gate-level 1-bit full adder; purely combinational, no state and no flow control.
// Shared by every bit position of the serial datapath.
module fa_bit_cell (
   output wire s,
   output wire cout,
   input  wire a,
   input  wire b,
   input  wire cin
);

   wire p;
   wire g;
   wire t;

   xor u_x0 (p, a, b);
   xor u_x1 (s, p, cin);
   and u_a0 (g, a, b);
   and u_a1 (t, p, cin);
   or  u_o0 (cout, g, t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract, LSB first; done pulses WIDTH+1 edges after the start edge, start ignored while busy.
// Signed overflow flag is built only when SERIAL_ADD_OVF_EN is defined, otherwise ovf is constant 0.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_a;
   logic fa_b;
   logic fa_s;
   logic fa_co;

   // Subtraction is a + ~b + 1: invert b per bit and seed the carry with op_sub.
   assign fa_a = a_q[cnt_q];
   assign fa_b = b_q[cnt_q] ^ sub_q;

   fa_bit_cell u_fa (
      .s    (fa_s),
      .cout (fa_co),
      .a    (fa_a),
      .b    (fa_b),
      .cin  (carry_q)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               a_d      = a;
               b_d      = b;
               sub_d    = op_sub;
               cnt_d    = '0;
               carry_d  = op_sub;
               result_d = '0;
               cout_d   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d    = 1'b0;
`endif
            end
         end
         RUN: begin
            result_d[cnt_q] = fa_s;
            carry_d         = fa_co;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q here is the carry into the MSB.
               ovf_d   = carry_q ^ fa_co;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign cout   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf    = ovf_q;
`else
   assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8; expectations come from a whole-word arithmetic model.
// The ovf expectation follows SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0]   t;
      logic [W-1:0] yy;
      exp_t         e;
      yy  = s ? ~y : y;
      t   = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
      e.r = t[W-1:0];
      e.c = t[W];
`ifdef SERIAL_ADD_OVF_EN
      e.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
`else
      e.v = 1'b0;
`endif
      return e;
   endfunction

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_res"},  result, e.r);
         chk({tag, "_cout"}, cout,   e.c);
         chk({tag, "_ovf"},  ovf,    e.v);
      end
   endtask

   // Drives one operation right away; glitch_at re-pulses start with other operands mid-RUN.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input int glitch_at, input string tag);
      int   n;
      bit   seen;
      exp_t e;
      e      = model(x, y, s);
      start  = 1'b1;
      a      = x;
      b      = y;
      op_sub = s;
      sb.push_back(e);
      n    = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            start = 1'b0;
            chk({tag, "_busy"}, busy, 1);
         end
         if (n == 2) begin
            a = 8'hC3;
            b = 8'h3C;
         end
         if (n == glitch_at) begin
            start  = 1'b1;
            a      = ~x;
            b      = 8'h5A;
            op_sub = ~s;
         end else if (n == glitch_at + 1) begin
            start = 1'b0;
         end
         if (done) seen = 1;
      end
      chk({tag, "_lat"}, n, 9);
      pop_check(tag);
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, {busy, done}, 0);
      chk({tag, "_hold"}, result, e.r);
   endtask

   initial begin
      int   d0;
      int   n;
      int   first;
      int   second;
      rst_n  = 1'b0;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res",  result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf",  ovf, 0);

      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h0F, 8'h01, 1'b0, 0, "add0f");
      do_op(8'hFF, 8'h01, 1'b0, 0, "addff");
      do_op(8'h05, 8'h07, 1'b1, 0, "sub57");
      do_op(8'h07, 8'h05, 1'b1, 0, "sub75");
      do_op(8'h7F, 8'h01, 1'b0, 0, "add7f");
      do_op(8'h00, 8'h80, 1'b1, 0, "sub080");

      d0 = done_cnt;
      do_op(8'h0F, 8'h01, 1'b0, 3, "glitch");
      repeat (4) @(posedge clk);
      #1;
      chk("glitch_dones", done_cnt - d0, 1);

      // Reset four RUN cycles into an operation with a non-zero partial result.
      @(negedge clk);
      start  = 1'b1;
      a      = 8'h33;
      b      = 8'h44;
      op_sub = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_partial", result, 8'h07);
      d0    = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_res",  result, 0);
      chk("mid_cout", cout, 0);
      chk("mid_ovf",  ovf, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("mid_nodone", done_cnt - d0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h33, 8'h44, 1'b0, 0, "after_rst");

      // Start held high: second operation accepted on the first IDLE edge after DONE.
      @(negedge clk);
      start  = 1'b1;
      a      = 8'h03;
      b      = 8'h04;
      op_sub = 1'b0;
      sb.push_back(model(8'h03, 8'h04, 1'b0));
      n      = 0;
      first  = 0;
      second = 0;
      while (second == 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 10) begin
            a      = 8'h90;
            b      = 8'h20;
            op_sub = 1'b1;
            sb.push_back(model(8'h90, 8'h20, 1'b1));
         end
         if (n == 11) chk("b2b_busy", busy, 1);
         if (n == 12) start = 1'b0;
         if (done) begin
            pop_check("b2b");
            if (first == 0) first = n;
            else second = n;
         end
      end
      chk("b2b_first",  first, 9);
      chk("b2b_second", second, 19);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
